// File: rtl/load_store_unit.sv
// Data-memory interface: turns single-cycle load/store intent into a request/ready bus
// transaction, stalling the datapath until the access completes or faults.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic        byte_access,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data,
    input  logic        bus_error
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [7:0]      count;
    logic            cap_byte;
    logic [1:0]      cap_lane;
    logic            request;
    logic            misaligned;
    logic [3:0][7:0] read_lanes;
    logic [31:0]     load_value;

    assign request    = memory_read | memory_write;
    assign misaligned = !byte_access && (address[1:0] != 2'b00);
    assign read_lanes = bus_read_data;

    // Byte loads pick the captured lane and zero-extend; word loads pass through.
    always_comb begin
        load_value = bus_read_data;
        if (cap_byte)
            load_value = {24'h0, read_lanes[cap_lane]};
    end

    // Stall rises in the same cycle as the request so the PC never advances past it.
    assign stall = reset && ((state == IDLE && request) || state == ACCESS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= 8'h0;
            cap_byte        <= 1'b0;
            cap_lane        <= 2'b00;
            read_data       <= 32'h0;
            fault           <= 1'b0;
            bus_request     <= 1'b0;
            bus_write       <= 1'b0;
            bus_address     <= 32'h0;
            bus_write_data  <= 32'h0;
            bus_byte_enable <= 4'h0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        bus_write       <= memory_write;
                        bus_address     <= {address[31:2], 2'b00};
                        bus_byte_enable <= byte_access ? (4'b0001 << address[1:0]) : 4'b1111;
                        bus_write_data  <= byte_access ? {4{write_data[7:0]}} : write_data;
                        cap_byte        <= byte_access;
                        cap_lane        <= address[1:0];
                        count           <= 8'h0;
                        if (misaligned) begin
                            fault     <= 1'b1;
                            read_data <= 32'h0;
                            state     <= DONE;
                        end else begin
                            bus_request <= 1'b1;
                            state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // A ready in the last allowed cycle still completes normally.
                    if (bus_ready) begin
                        bus_request <= 1'b0;
                        state       <= DONE;
                        if (bus_error) begin
                            fault     <= 1'b1;
                            read_data <= 32'h0;
                        end else if (!bus_write) begin
                            read_data <= load_value;
                        end
                    end else if (count == COUNT_LAST) begin
                        bus_request <= 1'b0;
                        fault       <= 1'b1;
                        read_data   <= 32'h0;
                        state       <= DONE;
                    end else begin
                        count <= count + 8'h1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        memory_read = 1'b0, memory_write = 1'b0, byte_access = 1'b0;
    logic [31:0] address = 32'h0, write_data = 32'h0;
    logic [31:0] read_data;
    logic        stall, fault, bus_request, bus_write;
    logic [31:0] bus_address, bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_ready = 1'b0, bus_error = 1'b0;
    logic [31:0] bus_read_data = 32'h0;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] model_rd = 32'h0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .memory_read(memory_read), .memory_write(memory_write), .byte_access(byte_access),
        .address(address), .write_data(write_data),
        .read_data(read_data), .stall(stall), .fault(fault),
        .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
        .bus_write_data(bus_write_data), .bus_byte_enable(bus_byte_enable),
        .bus_ready(bus_ready), .bus_read_data(bus_read_data), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One access from request to DONE. waits = cycles of ACCESS before bus_ready;
    // waits >= TO means ready is withheld entirely.
    task automatic run_txn(input bit is_wr, input bit is_byte, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] bdata,
                           input int waits, input bit err, input bit hold);
        bit          misal, tmo, flt;
        int          exp_req, stall_cnt, req_cnt, guard;
        logic [31:0] exp_be, exp_wd, exp_adr;
        misal   = !is_byte && (addr % 4 != 0);
        tmo     = !misal && waits >= TO;
        flt     = misal || tmo || err;
        exp_req = misal ? 0 : (tmo ? TO : waits + 1);
        exp_be  = is_byte ? (32'd1 << (addr % 4)) : 32'd15;
        exp_wd  = is_byte ? wdata[7:0] * 32'h01010101 : wdata;
        exp_adr = addr - (addr % 4);
        if (flt)         model_rd = 32'h0;
        else if (!is_wr) model_rd = is_byte ? (bdata >> (8 * (addr % 4))) % 256 : bdata;

        @(negedge clock);
        memory_write = is_wr;
        memory_read  = is_wr ? 1'($urandom % 2) : 1'b1;
        byte_access  = is_byte;
        address      = addr;
        write_data   = wdata;
        #1;
        stall_cnt = 0; req_cnt = 0; guard = 0;
        while (stall && guard < 300) begin
            stall_cnt++; guard++;
            chk("req_level", {31'h0, bus_request}, {31'h0, stall_cnt > 1 && !misal});
            if (bus_request) begin
                req_cnt++;
                chk("bus_address", bus_address, exp_adr);
                chk("bus_be", {28'h0, bus_byte_enable}, exp_be);
                chk("bus_wdata", bus_write_data, exp_wd);
                chk("bus_write", {31'h0, bus_write}, {31'h0, is_wr});
            end
            bus_ready     = 1'b0;
            bus_error     = 1'($urandom % 2);
            bus_read_data = $urandom;
            if (bus_request && !tmo && req_cnt == waits + 1) begin
                bus_ready     = 1'b1;
                bus_error     = err;
                bus_read_data = bdata;
            end
            @(negedge clock);
            if (!hold) begin
                memory_read  = 1'b0;
                memory_write = 1'b0;
            end
            #1;
        end
        bus_ready = 1'b0;
        bus_error = 1'b0;
        if (guard >= 300) chk("stall_bound", 32'd1, 32'd0);
        chk("stall_cycles", stall_cnt, exp_req + 1);
        chk("req_cycles", req_cnt, exp_req);
        chk("done_fault", {31'h0, fault}, {31'h0, flt});
        chk("done_rdata", read_data, model_rd);
        chk("done_req", {31'h0, bus_request}, 32'h0);
        if (!hold) begin
            bus_ready = 1'($urandom % 2);
            @(negedge clock);
            #1;
            chk("fault_pulse", {31'h0, fault}, 32'h0);
            chk("idle_rdata", read_data, model_rd);
            chk("idle_stall", {31'h0, stall}, 32'h0);
            bus_ready = 1'b0;
        end
    endtask

    initial begin
        memory_read = 1'b1;
        #12;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_req", {31'h0, bus_request}, 32'h0);
        chk("rst_be", {28'h0, bus_byte_enable}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        memory_read = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        run_txn(0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 0);
        run_txn(0, 1, 32'h103, 32'h0, 32'hA1B2C3D4, 0, 0, 0);
        run_txn(0, 1, 32'h101, 32'h0, 32'hA1B2C3D4, 1, 0, 0);
        run_txn(1, 1, 32'h202, 32'h12345678, 32'h0, 0, 0, 0);
        run_txn(0, 0, 32'h102, 32'h0, 32'h55555555, 0, 0, 0);
        run_txn(0, 0, 32'h104, 32'h0, 32'h66666666, 10, 0, 0);
        run_txn(0, 0, 32'h108, 32'h0, 32'h77777777, TO - 1, 0, 0);
        run_txn(1, 0, 32'h10C, 32'hCAFEF00D, 32'h0, 1, 1, 0);
        run_txn(0, 0, 32'h110, 32'h0, 32'h11111111, 0, 0, 1);
        run_txn(0, 0, 32'h110, 32'h0, 32'h11111111, 0, 0, 0);

        // Reset in the middle of an access.
        @(negedge clock);
        memory_read = 1'b1; byte_access = 1'b0; address = 32'h300;
        @(negedge clock);
        #1;
        chk("pre_rst_req", {31'h0, bus_request}, 32'h1);
        #1 reset = 1'b0;
        #1;
        model_rd = 32'h0;
        chk("arst_req", {31'h0, bus_request}, 32'h0);
        chk("arst_stall", {31'h0, stall}, 32'h0);
        chk("arst_fault", {31'h0, fault}, 32'h0);
        chk("arst_rdata", read_data, 32'h0);
        chk("arst_addr", bus_address, 32'h0);
        chk("arst_wdata", bus_write_data, 32'h0);
        chk("arst_wr", {31'h0, bus_write}, 32'h0);
        memory_read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("post_rst_stall", {31'h0, stall}, 32'h0);
        chk("post_rst_req", {31'h0, bus_request}, 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            bit          b;
            b = 1'($urandom % 2);
            a = $urandom;
            if (!b && ($urandom % 2 == 1)) a = a & 32'hFFFFFFFC;
            run_txn(1'($urandom % 2), b, a, $urandom, $urandom,
                    $urandom_range(0, 5), 1'($urandom % 5 == 0), (i < 149) && ($urandom % 4 == 0));
        end
        memory_read  = 1'b0;
        memory_write = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
